trng_byte_harvester: RTL and testbench
======================================

Name: trng_byte_harvester

Overview:
- Consumer side of the ring-oscillator sampler.
- Drives the two RO enables and waits a warm-up period before sampling. Captures the sampler's 16-bit XOR word at a programmed rate.
- Runs a repetition-count health test on the raw words, then applies von Neumann debiasing (or a bypass).
- Packs the result into bytes and delivers them over a valid/ready interface.

Parameters:
- WARMUP_CYCLES, 16, cycles ROs run after enable before the first capture (>=1).
- SAMPLE_GAP, 4, idle cycles between the end of one word's extraction and the next capture (0 allowed).
- REP_LIMIT, 4, count of consecutive identical raw words that trips the health fault (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- enable  in  1  level; 1 = harvest, 0 = stop.
- vn_bypass  in  1  1 = raw even bits, 0 = von Neumann extraction.
- raw_in  in  16  sampler XOR word, registered on clk by the sampler.
- ro_activate_1  out  1  RO1 enable.
- ro_activate_2  out  1  RO2 enable.
- byte_out  out  8  harvested byte.
- byte_valid  out  1  byte_out holds an unconsumed byte.
- byte_ready  in  1  consumer accepts byte_out.
- health_fail  out  1  sticky fault flag.
- clear_fail  in  1  clears the fault and returns to IDLE.

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-high; clock clk.
- Reset values: all outputs 0. State IDLE. Internal accumulator, counters, previous-word register and prev_valid all 0.
- ro_activate_1 = ro_activate_2 = 1 exactly in WARMUP, CAPTURE, EXTRACT and WAIT. Both are registered outputs.
- IDLE: prev_valid=0, rep_cnt=0. If enable=1 at a clock edge -> WARMUP.
- WARMUP: stays WARMUP_CYCLES cycles, then -> CAPTURE.
- CAPTURE (1 cycle): word <= raw_in.
  - If prev_valid and raw_in==prev, rep_cnt+1; else rep_cnt=1.
  - prev <= raw_in; prev_valid=1.
  - If the new rep_cnt == REP_LIMIT -> FAULT; else -> EXTRACT with pair index 0.
- EXTRACT: processes one pair i per cycle, i=0..7, with a=word[2i], b=word[2i+1].
  - vn_bypass=1: emit a.
  - vn_bypass=0: emit a only if a!=b; otherwise nothing.
  - Emitted bits fill the accumulator LSB-first (first bit -> bit 0).
  - After pair 7 -> WAIT, or -> CAPTURE if SAMPLE_GAP=0.
- WAIT: SAMPLE_GAP cycles, then -> CAPTURE.
- Byte completion: when an emitted bit is the 8th, {bit,acc[6:0]} loads byte_out and byte_valid=1 on the same edge; the accumulator count resets to 0.
- Output handshake:
  - A transfer occurs on any edge with byte_valid & byte_ready.
  - byte_out is stable while byte_valid=1.
  - If a byte would complete while byte_valid=1 and byte_ready=0, EXTRACT stalls: pair index does not advance and nothing is emitted. The stall holds until byte_ready=1.
  - Transfer and new load on the same edge are allowed; byte_valid stays 1 with the new byte.
- Latency: enable seen at edge E0 -> first byte (bypass) has byte_valid=1 after edge E0+WARMUP_CYCLES+9.
- enable=0 in any non-FAULT state:
  - Next edge -> IDLE; ROs off.
  - Partial accumulator is discarded; rep_cnt cleared.
  - A pending byte_out/byte_valid is retained and still deliverable.
- FAULT:
  - ROs off; health_fail=1 on entry.
  - byte_valid forced to 0 (pending byte dropped); accumulator cleared.
  - Holds regardless of enable until clear_fail=1. Then -> IDLE at that edge and health_fail=0.
  - clear_fail outside FAULT is ignored.
- Asynchronous reset mid-operation: returns everything to reset values immediately, including health_fail.
- rep_cnt saturates at REP_LIMIT; its width is sized for REP_LIMIT.

Test Plan:
- Bypass word: WARMUP_CYCLES=16, vn_bypass=1, raw_in=16'hA5C3 held, enable at E0, byte_ready=1.
  - ROs go high after E0.
  - byte_valid rises after E0+25 with byte_out=8'h39.
- Von Neumann word: vn_bypass=0, raw_in=16'h9999 constant, byte_ready=1.
  - Bytes 8'h55 x3.
  - The 4th capture trips FAULT: health_fail=1, ROs 0, no 4th byte.
- No yield: vn_bypass=0, raw_in=16'h0000.
  - No byte_valid ever.
  - FAULT after the 4th capture; clear_fail pulse -> IDLE, health_fail=0.
- Backpressure: byte_ready=0 with varying raw_in.
  - First byte held stable; EXTRACT stalls with ROs still on.
  - byte_ready=1 for one cycle: transfer, then the next byte loads; no bit lost or duplicated versus a reference model.
- Abort: deassert enable mid-EXTRACT with a byte pending.
  - IDLE next edge, ROs off; pending byte still transfers.
  - Re-enable repeats the full warm-up.
- Reset: assert rst_n mid-WAIT and in FAULT.
  - All outputs 0 immediately (asynchronous), including health_fail.

Source files
------------

// File: rtl/trng_byte_harvester.sv
// Ring-oscillator consumer: warm-up, periodic word capture, repetition-count health test,
// von Neumann (or bypass) extraction and byte packing onto a valid/ready output.
module trng_byte_harvester #(
   parameter int WARMUP_CYCLES = 16,
   parameter int SAMPLE_GAP    = 4,
   parameter int REP_LIMIT     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        vn_bypass,
   input  logic [15:0] raw_in,
   output logic        ro_activate_1,
   output logic        ro_activate_2,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        health_fail,
   input  logic        clear_fail
);

   localparam int CntMax = (WARMUP_CYCLES > SAMPLE_GAP) ? WARMUP_CYCLES : SAMPLE_GAP;
   localparam int CntW   = $clog2(CntMax + 1);
   localparam int RepW   = $clog2(REP_LIMIT + 1);

   localparam logic [CntW-1:0] WarmLast = CntW'(WARMUP_CYCLES - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(SAMPLE_GAP - 1);
   localparam logic [RepW-1:0] RepMax   = RepW'(REP_LIMIT);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StWarmup  = 3'd1;
   localparam logic [2:0] StCapture = 3'd2;
   localparam logic [2:0] StExtract = 3'd3;
   localparam logic [2:0] StWait    = 3'd4;
   localparam logic [2:0] StFault   = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [RepW-1:0] rep_q, rep_d, rep_new;
   logic [15:0]     prev_q, prev_d;
   logic            prev_valid_q, prev_valid_d;
   logic [15:0]     word_q, word_d;
   logic [2:0]      pair_q, pair_d;
   logic [6:0]      acc_q, acc_d;
   logic [2:0]      acc_cnt_q, acc_cnt_d;
   logic [7:0]      byte_q, byte_d;
   logic            byte_valid_q, byte_valid_d;
   logic            health_fail_q, health_fail_d;
   logic            ro_q, ro_d;

   logic [1:0] pair_bits;
   logic       emit;
   logic       stall;

   assign pair_bits = word_q[{pair_q, 1'b0} +: 2];
   assign emit      = vn_bypass || (pair_bits[0] != pair_bits[1]);
   // A completing bit cannot land while the previous byte is still unconsumed.
   assign stall     = emit && (acc_cnt_q == 3'd7) && byte_valid_q && !byte_ready;

   always_comb begin
      if (prev_valid_q && (raw_in == prev_q)) begin
         rep_new = (rep_q == RepMax) ? RepMax : rep_q + RepW'(1);
      end else begin
         rep_new = RepW'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rep_d         = rep_q;
      prev_d        = prev_q;
      prev_valid_d  = prev_valid_q;
      word_d        = word_q;
      pair_d        = pair_q;
      acc_d         = acc_q;
      acc_cnt_d     = acc_cnt_q;
      byte_d        = byte_q;
      byte_valid_d  = byte_valid_q;
      health_fail_d = health_fail_q;

      if (byte_valid_q && byte_ready) begin
         byte_valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            prev_valid_d = 1'b0;
            rep_d        = '0;
            cnt_d        = '0;
            if (enable) begin
               state_d = StWarmup;
            end
         end
         StFault: begin
            byte_valid_d = 1'b0;
            if (clear_fail) begin
               state_d       = StIdle;
               health_fail_d = 1'b0;
            end
         end
         default: begin
            if (!enable) begin
               // Abort: partial bits are dropped, a pending byte stays deliverable.
               state_d      = StIdle;
               acc_d        = '0;
               acc_cnt_d    = '0;
               rep_d        = '0;
               prev_valid_d = 1'b0;
            end else begin
               unique case (state_q)
                  StWarmup: begin
                     if (cnt_q == WarmLast) begin
                        state_d = StCapture;
                     end else begin
                        cnt_d = cnt_q + CntW'(1);
                     end
                  end
                  StCapture: begin
                     word_d       = raw_in;
                     prev_d       = raw_in;
                     prev_valid_d = 1'b1;
                     rep_d        = rep_new;
                     if (rep_new == RepMax) begin
                        state_d       = StFault;
                        health_fail_d = 1'b1;
                        byte_valid_d  = 1'b0;
                        acc_d         = '0;
                        acc_cnt_d     = '0;
                     end else begin
                        state_d = StExtract;
                        pair_d  = 3'd0;
                     end
                  end
                  StExtract: begin
                     if (!stall) begin
                        if (emit) begin
                           if (acc_cnt_q == 3'd7) begin
                              byte_d       = {pair_bits[0], acc_q};
                              byte_valid_d = 1'b1;
                              acc_d        = '0;
                              acc_cnt_d    = 3'd0;
                           end else begin
                              // Shift in at the top so the first bit ends at bit 0.
                              acc_d     = {pair_bits[0], acc_q[6:1]};
                              acc_cnt_d = acc_cnt_q + 3'd1;
                           end
                        end
                        if (pair_q == 3'd7) begin
                           cnt_d   = '0;
                           state_d = (SAMPLE_GAP == 0) ? StCapture : StWait;
                        end else begin
                           pair_d = pair_q + 3'd1;
                        end
                     end
                  end
                  StWait: begin
                     if (cnt_q == GapLast) begin
                        state_d = StCapture;
                     end else begin
                        cnt_d = cnt_q + CntW'(1);
                     end
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
      endcase

      ro_d = (state_d == StWarmup) || (state_d == StCapture) ||
             (state_d == StExtract) || (state_d == StWait);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         rep_q         <= '0;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         word_q        <= '0;
         pair_q        <= '0;
         acc_q         <= '0;
         acc_cnt_q     <= '0;
         byte_q        <= '0;
         byte_valid_q  <= 1'b0;
         health_fail_q <= 1'b0;
         ro_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rep_q         <= rep_d;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         word_q        <= word_d;
         pair_q        <= pair_d;
         acc_q         <= acc_d;
         acc_cnt_q     <= acc_cnt_d;
         byte_q        <= byte_d;
         byte_valid_q  <= byte_valid_d;
         health_fail_q <= health_fail_d;
         ro_q          <= ro_d;
      end
   end

   assign ro_activate_1 = ro_q;
   assign ro_activate_2 = ro_q;
   assign byte_out      = byte_q;
   assign byte_valid    = byte_valid_q;
   assign health_fail   = health_fail_q;

endmodule

// File: tb/tb_trng_byte_harvester.sv
// Directed bench for trng_byte_harvester: bypass/VN bytes, health fault, backpressure,
// abort and asynchronous reset, with cycle counts measured from the enabling edge.
module tb_trng_byte_harvester;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        vn_bypass;
   logic [15:0] raw_in;
   logic        ro_activate_1;
   logic        ro_activate_2;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        health_fail;
   logic        clear_fail;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int nbytes;

   trng_byte_harvester dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .vn_bypass     (vn_bypass),
      .raw_in        (raw_in),
      .ro_activate_1 (ro_activate_1),
      .ro_activate_2 (ro_activate_2),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .health_fail   (health_fail),
      .clear_fail    (clear_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check(tag, {19'd0, ro_activate_1, ro_activate_2, byte_valid, health_fail, byte_out},
            32'd0);
   endtask

   // Sample 1 time unit after each rising edge; cyc counts edges since the enabling edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) step();
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      vn_bypass  = 1'b0;
      raw_in     = 16'h0000;
      byte_ready = 1'b0;
      clear_fail = 1'b0;
      #2 rst_n = 1'b1;
      #1 check_zero("reset_outputs");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      step();
      check_zero("idle_after_reset");

      // Bypass word A5C3: even bits give 8'h39 after E0+25.
      vn_bypass  = 1'b1;
      raw_in     = 16'hA5C3;
      byte_ready = 1'b1;
      enable     = 1'b1;
      cyc        = -1;
      step();
      check("bypass_ro1_on", {31'd0, ro_activate_1}, 32'd1);
      check("bypass_ro2_on", {31'd0, ro_activate_2}, 32'd1);
      step_to(5);
      clear_fail = 1'b1;
      step();
      clear_fail = 1'b0;
      check("clear_ignored_ro", {31'd0, ro_activate_1}, 32'd1);
      step_to(24);
      check("bypass_no_early_byte", {31'd0, byte_valid}, 32'd0);
      step();
      check("bypass_valid_e25", {31'd0, byte_valid}, 32'd1);
      check("bypass_byte", {24'd0, byte_out}, 32'h39);
      step();
      check("bypass_consumed", {31'd0, byte_valid}, 32'd0);
      enable = 1'b0;
      step();
      check("bypass_stop_ro", {30'd0, ro_activate_1, ro_activate_2}, 32'd0);
      step();

      // Von Neumann on 9999: one 8'h55 per word, fourth identical capture faults at E0+56.
      vn_bypass = 1'b0;
      raw_in    = 16'h9999;
      enable    = 1'b1;
      nbytes    = 0;
      cyc       = -1;
      step();
      while (cyc < 80 && health_fail !== 1'b1) begin
         step();
         if (byte_valid === 1'b1) begin
            check("vn_byte", {24'd0, byte_out}, 32'h55);
            check("vn_byte_cycle", cyc, 25 + 13 * nbytes);
            nbytes++;
         end
      end
      check("vn_fault_cycle", cyc, 56);
      check("vn_byte_count", nbytes, 3);
      check("vn_fault_flag", {31'd0, health_fail}, 32'd1);
      check("vn_fault_ro", {30'd0, ro_activate_1, ro_activate_2}, 32'd0);
      check("vn_fault_no_valid", {31'd0, byte_valid}, 32'd0);
      step();
      step();
      step();
      check("fault_holds_with_enable", {31'd0, health_fail}, 32'd1);
      check("fault_holds_ro_off", {31'd0, ro_activate_1}, 32'd0);
      enable     = 1'b0;
      clear_fail = 1'b1;
      step();
      clear_fail = 1'b0;
      check("vn_clear", {31'd0, health_fail}, 32'd0);

      // No yield: all-zero word never emits, faults on the fourth capture.
      raw_in = 16'h0000;
      enable = 1'b1;
      nbytes = 0;
      cyc    = -1;
      step();
      while (cyc < 80 && health_fail !== 1'b1) begin
         step();
         if (byte_valid === 1'b1) nbytes++;
      end
      check("noyield_bytes", nbytes, 0);
      check("noyield_fault_cycle", cyc, 56);
      enable     = 1'b0;
      clear_fail = 1'b1;
      step();
      clear_fail = 1'b0;
      check("noyield_clear", {31'd0, health_fail}, 32'd0);
      step();
      check("noyield_idle_ro", {31'd0, ro_activate_1}, 32'd0);

      // Backpressure: words A5C3, 5555, 0F0F captured at E0+17, +30, +51.
      vn_bypass  = 1'b1;
      raw_in     = 16'hA5C3;
      byte_ready = 1'b0;
      enable     = 1'b1;
      cyc        = -1;
      step();
      step_to(17);
      raw_in = 16'h5555;
      step_to(25);
      check("bp_first_valid", {31'd0, byte_valid}, 32'd1);
      check("bp_first_byte", {24'd0, byte_out}, 32'h39);
      step_to(30);
      raw_in = 16'h0F0F;
      step_to(40);
      check("bp_hold_byte", {24'd0, byte_out}, 32'h39);
      check("bp_stall_ro", {30'd0, ro_activate_1, ro_activate_2}, 32'd3);
      step_to(45);
      check("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
      byte_ready = 1'b1;
      step();
      byte_ready = 1'b0;
      check("bp_second_valid", {31'd0, byte_valid}, 32'd1);
      check("bp_second_byte", {24'd0, byte_out}, 32'hFF);
      step_to(60);
      check("bp_second_hold", {24'd0, byte_out}, 32'hFF);
      byte_ready = 1'b1;
      step();
      check("bp_third_byte", {24'd0, byte_out}, 32'h33);
      step();
      check("bp_third_taken", {31'd0, byte_valid}, 32'd0);
      enable = 1'b0;
      step();
      step();

      // Abort mid-extract with a byte pending, then a full fresh warm-up.
      raw_in     = 16'hA5C3;
      byte_ready = 1'b0;
      enable     = 1'b1;
      cyc        = -1;
      step();
      step_to(17);
      raw_in = 16'h5555;
      step_to(33);
      enable = 1'b0;
      step();
      check("abort_ro_off", {30'd0, ro_activate_1, ro_activate_2}, 32'd0);
      check("abort_pending_valid", {31'd0, byte_valid}, 32'd1);
      check("abort_pending_byte", {24'd0, byte_out}, 32'h39);
      byte_ready = 1'b1;
      step();
      check("abort_pending_taken", {31'd0, byte_valid}, 32'd0);
      raw_in = 16'h0F0F;
      enable = 1'b1;
      cyc    = -1;
      step();
      check("reenable_ro", {31'd0, ro_activate_1}, 32'd1);
      step_to(24);
      check("reenable_no_early", {31'd0, byte_valid}, 32'd0);
      step();
      check("reenable_valid", {31'd0, byte_valid}, 32'd1);
      check("reenable_byte", {24'd0, byte_out}, 32'h33);
      enable = 1'b0;
      step();
      step();

      // Asynchronous reset in WAIT with a byte pending.
      raw_in     = 16'hA5C3;
      byte_ready = 1'b0;
      enable     = 1'b1;
      cyc        = -1;
      step();
      step_to(27);
      check("wait_pending", {31'd0, byte_valid}, 32'd1);
      rst_n = 1'b1;
      #1 check_zero("reset_in_wait");
      enable = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;

      // Asynchronous reset while in FAULT.
      vn_bypass  = 1'b0;
      raw_in     = 16'h0000;
      byte_ready = 1'b1;
      enable     = 1'b1;
      cyc        = -1;
      step();
      while (cyc < 80 && health_fail !== 1'b1) step();
      check("fault_before_reset", {31'd0, health_fail}, 32'd1);
      rst_n = 1'b1;
      #1 check_zero("reset_in_fault");
      enable = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      step();
      check_zero("idle_after_fault_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
